// File: rtl/cpe_mem_arbiter.sv
// cpe_mem_arbiter: shares one single-port, fixed-latency, word-wide memory
// between the CPU fetch port and the data load/store port. Data has priority
// over fetch until fetch has waited STARVE_MAX data grants. Data accesses are
// translated to big-endian byte enables, lane-replicated write data and
// right-aligned, zero-extended read data.
module cpe_mem_arbiter #(
    parameter int ADDR_W     = 16,  // byte-address bits used; higher bits wrap
    parameter int MEM_LAT    = 2,   // mem_en cycle to mem_rdata valid, >= 1
    parameter int STARVE_MAX = 4    // consecutive data grants while fetch waits, >= 1
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_l,
    input  logic              if_req_w_i_h,
    input  logic [31:0]       if_addr_w_i,
    output logic              if_ack_w_o_h,
    output logic [31:0]       if_data_w_o,
    input  logic              d_rd_w_i_h,
    input  logic              d_wr_w_i_h,
    input  logic [31:0]       d_addr_w_i,
    input  logic [31:0]       d_wdata_w_i,
    input  logic [1:0]        d_byte_sel_w_i,
    output logic              d_ack_w_o_h,
    output logic [31:0]       d_rdata_w_o,
    output logic              mem_en_w_o_h,
    output logic              mem_we_w_o_h,
    output logic [ADDR_W-3:0] mem_addr_w_o,
    output logic [3:0]        mem_be_w_o,
    output logic [31:0]       mem_wdata_w_o,
    input  logic [31:0]       mem_rdata_w_i
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [STV_W-1:0] starve_q;
    logic             gnt_if_q;   // granted port: 1 = fetch, 0 = data
    logic             gnt_wr_q;   // granted data access is a write
    logic [31:0]      if_data_q;
    logic [31:0]      d_rdata_q;

    logic d_req, grant, grant_if, cnt_last;

    // Big-endian byte enables: bit 3 is the lowest-addressed byte.
    function automatic logic [3:0] data_be(input logic [1:0] sel, input logic [1:0] a);
        case (sel)
            2'b00:   return 4'b1000 >> a;
            2'b01:   return a[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data into every lane it could target.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sel, input logic [31:0] wd);
        case (sel)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Pick the addressed lane out of the memory word and right-align it.
    function automatic logic [31:0] lane_rdata(input logic [1:0] sel, input logic [1:0] a,
                                               input logic [31:0] rd);
        case (sel)
            2'b00: begin
                case (a)
                    2'd0:    return {24'b0, rd[31:24]};
                    2'd1:    return {24'b0, rd[23:16]};
                    2'd2:    return {24'b0, rd[15:8]};
                    default: return {24'b0, rd[7:0]};
                endcase
            end
            2'b01:   return a[1] ? {16'b0, rd[15:0]} : {16'b0, rd[31:16]};
            default: return rd;
        endcase
    endfunction

    assign d_req    = d_rd_w_i_h | d_wr_w_i_h;
    assign grant    = (state_q == S_IDLE) && (if_req_w_i_h || d_req);
    // Fetch wins when it is alone or when data has used up its starvation budget.
    assign grant_if = if_req_w_i_h && (!d_req || starve_q == STV_W'(STARVE_MAX));
    assign cnt_last = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));

    // Address bits beyond the wrap width, and the fetch byte offset, are don't-care.
    logic unused_addr_bits;
    if (ADDR_W < 32) begin : g_wrap
        assign unused_addr_bits = ^{if_addr_w_i[31:ADDR_W], if_addr_w_i[1:0], d_addr_w_i[31:ADDR_W]};
    end else begin : g_nowrap
        assign unused_addr_bits = ^if_addr_w_i[1:0];
    end

    // State register.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!res_w_i_l) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: memory strobe and operands in ISSUE, ack of the granted port in DONE.
    always_comb begin
        mem_en_w_o_h  = 1'b0;
        mem_we_w_o_h  = 1'b0;
        mem_addr_w_o  = '0;
        mem_be_w_o    = 4'b0000;
        mem_wdata_w_o = '0;
        if_ack_w_o_h  = (state_q == S_DONE) && gnt_if_q;
        d_ack_w_o_h   = (state_q == S_DONE) && !gnt_if_q;
        if (state_q == S_ISSUE) begin
            mem_en_w_o_h = 1'b1;
            if (gnt_if_q) begin
                mem_addr_w_o = if_addr_w_i[ADDR_W-1:2];
                mem_be_w_o   = 4'b1111;
            end else begin
                mem_we_w_o_h = gnt_wr_q;
                mem_addr_w_o = d_addr_w_i[ADDR_W-1:2];
                mem_be_w_o   = data_be(d_byte_sel_w_i, d_addr_w_i[1:0]);
                if (gnt_wr_q) mem_wdata_w_o = lane_wdata(d_byte_sel_w_i, d_wdata_w_i);
            end
        end
    end

    assign if_data_w_o = if_data_q;
    assign d_rdata_w_o = d_rdata_q;

    // Grant bookkeeping, latency countdown and read-data capture.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            cnt_q     <= '0;
            starve_q  <= '0;
            gnt_if_q  <= 1'b0;
            gnt_wr_q  <= 1'b0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                gnt_if_q <= grant_if;
                // A simultaneous read and write performs only the write.
                gnt_wr_q <= !grant_if && d_wr_w_i_h;
                if (grant_if || !if_req_w_i_h)
                    starve_q <= '0;
                else if (starve_q != STV_W'(STARVE_MAX))
                    starve_q <= starve_q + STV_W'(1);
            end
            if (state_q == S_ISSUE)     cnt_q <= CNT_W'(MEM_LAT);
            else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_last) begin
                if (gnt_if_q)
                    if_data_q <= mem_rdata_w_i;
                else if (!gnt_wr_q)
                    d_rdata_q <= lane_rdata(d_byte_sel_w_i, d_addr_w_i[1:0], mem_rdata_w_i);
            end
        end
    end

endmodule

// File: doc/cpe_mem_arbiter.md
Name: cpe_mem_arbiter

Overview:
Shares one single-port, fixed-latency, word-wide memory between the CPU instruction-fetch port and the data load/store port. It arbitrates requests, with data priority bounded by a starvation limit. It converts byte-select accesses into big-endian byte enables, lane-replicated write data, and extracted read data. It sits between cpe_cpu and the unified memory model or SRAM macro.

Parameters:
ADDR_W, 16, byte-address bits used; higher address bits are ignored, so addresses wrap.
MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; minimum 1.
STARVE_MAX, 4, maximum consecutive data grants while fetch is waiting; minimum 1.

Ports:
clk_w_i  in  1  clock, rising edge
res_w_i_l  in  1  asynchronous active-low reset
if_req_w_i_h  in  1  fetch request, held until ack
if_addr_w_i  in  32  fetch byte address
if_ack_w_o_h  out  1  one-cycle fetch done pulse
if_data_w_o  out  32  fetched word; valid while ack is high
d_rd_w_i_h  in  1  data read request
d_wr_w_i_h  in  1  data write request
d_addr_w_i  in  32  data byte address
d_wdata_w_i  in  32  write data, right-aligned
d_byte_sel_w_i  in  2  access size: 00 byte, 01 half, 10 or 11 word
d_ack_w_o_h  out  1  one-cycle data done pulse
d_rdata_w_o  out  32  read data, zero-extended and right-aligned
mem_en_w_o_h  out  1  memory access strobe
mem_we_w_o_h  out  1  memory write strobe
mem_addr_w_o  out  ADDR_W-2  word index, equal to addr[ADDR_W-1:2]
mem_be_w_o  out  4  byte enables; bit 3 is the MSB byte (lowest address)
mem_wdata_w_o  out  32  memory write data
mem_rdata_w_i  in  32  memory read data

Behaviour:
- Reset (asynchronous, res_w_i_l=0):
  - All outputs go to 0 immediately.
  - State goes to IDLE; the latency counter and starve counter clear.
  - Any in-flight transaction is dropped and no ack is issued.
- States:
  - IDLE: sample requests. On a grant, go to ISSUE.
  - ISSUE (1 cycle): mem_en=1; mem_we=1 for writes; address, be and wdata driven. Load cnt=MEM_LAT and go to WAIT.
  - WAIT: decrement cnt each cycle. In the cycle where cnt==1, capture mem_rdata_w_i and go to DONE.
  - DONE (1 cycle): raise the ack of the granted port and present the read data. Go to IDLE.
- Latency: requests are seen in IDLE at cycle t, mem_en is high at t+1, and ack is high at t+2+MEM_LAT. Writes have the same latency as reads.
- Handshake rules:
  - The requester holds req and all operands stable until ack.
  - The req value in the cycle after ack is a new request.
  - Requests are sampled only in IDLE.
  - if_data and d_rdata hold their last value until the next ack.
- Arbitration in IDLE:
  - Data only: grant data. Fetch only: grant fetch.
  - Both requesting: grant data unless starve_cnt==STARVE_MAX, in which case grant fetch.
  - starve_cnt increments on a data grant while if_req is high (saturates at STARVE_MAX).
  - starve_cnt clears on a fetch grant, or on a data grant while if_req is low.
- Simultaneous d_rd and d_wr: perform the write only; d_ack pulses once and d_rdata is unchanged.
- Fetch accesses: always word size, be=1111, if_addr[1:0] ignored, mem_we=0.
- Data accesses, using a = addr[1:0] (big-endian):
  - Byte: be = 1000>>a; wdata = the byte replicated into all 4 lanes; read returns lane a zero-extended.
  - Half: a[0] is ignored. a[1]=0 gives be=1100 and upper half; a[1]=1 gives be=0011 and lower half. wdata = the half replicated into both halves.
  - Word: be=1111; a is ignored.
- Address wrap: mem_addr uses only addr[ADDR_W-1:2]. Addresses 0x0001_0008 and 0x0008 access the same word when ADDR_W=16.

Test Plan:
1. Reset with res_w_i_l=0 while requests are active -> all outputs 0; no ack until 2 cycles after reset release plus a request.
2. MEM_LAT=2; fetch req at cycle 0 with if_addr=0x8; mem returns 0x00100093 -> mem_en high at cycle 1 with mem_addr=2, be=1111; if_ack high at cycle 4 with if_data=0x00100093.
3. Byte write: addr 0x13, wdata 0xAB, sel 00 -> be=0001, mem_wdata=0xABABABAB, we=1. Half read: addr 0x12, mem=0x1122AB44 -> d_rdata=0x0000AB44.
4. Contention: both ports requesting continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
5. d_rd and d_wr both high on word addr 0x4 -> exactly one mem_en with we=1, a single d_ack, and d_rdata unchanged.
6. Reset asserted during WAIT -> outputs drop to 0 immediately with no ack. After release, a new data read at addr 0x10014 (ADDR_W=16) -> mem_addr=5 and the ack arrives with normal latency.
